// File: rtl/input_port_cluster_gen_pkg.sv
// Shared packet field layout and channel helpers for the input port cluster.
// Fields from the MSB down: valid, dst_leaf, dst_port, src_leaf, src_port, reserved, payload.
package input_port_cluster_gen_pkg;

    localparam int unsigned PACKET_BITS   = 97;
    localparam int unsigned NUM_LEAF_BITS = 6;
    localparam int unsigned NUM_PORT_BITS = 4;
    localparam int unsigned PAYLOAD_BITS  = 64;
    localparam int unsigned CNT_BITS      = 32;
    localparam int unsigned CTRL_BITS     = NUM_LEAF_BITS + NUM_PORT_BITS;

    localparam int unsigned VALID_POS    = PACKET_BITS - 1;
    localparam int unsigned DST_LEAF_LSB = VALID_POS - NUM_LEAF_BITS;
    localparam int unsigned DST_PORT_LSB = DST_LEAF_LSB - NUM_PORT_BITS;
    localparam int unsigned SRC_LEAF_LSB = DST_PORT_LSB - NUM_LEAF_BITS;
    localparam int unsigned SRC_PORT_LSB = SRC_LEAF_LSB - NUM_PORT_BITS;

    // LSB of channel chan's {src_leaf, src_port} slice in the control register.
    function automatic int unsigned ctrl_lsb(input int unsigned chan);
        return chan * CTRL_BITS;
    endfunction

endpackage

// File: rtl/input_port_cluster_gen_chan.sv
// One input channel: payload FIFO, beat packer with valid/ack, credit pulse and statistics.
module input_port_cluster_gen_chan
    import input_port_cluster_gen_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH_BITS       = 7,
    parameter int unsigned WORDS_PER_BEAT        = 4,
    parameter int unsigned FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_wr,
    input  logic [PAYLOAD_BITS-1:0]                i_wdata,
    input  logic                                   i_ack,
    input  logic                                   i_done,
    output logic [PAYLOAD_BITS*WORDS_PER_BEAT-1:0] o_dout,
    output logic                                   o_vld,
    output logic                                   o_credit,
    output logic [CNT_BITS-1:0]                    o_full_cnt,
    output logic [CNT_BITS-1:0]                    o_empty_cnt,
    output logic [CNT_BITS-1:0]                    o_read_cnt,
    output logic                                   o_overflow,
    output logic                                   o_stall
);

    localparam int unsigned DEPTH     = 2 ** FIFO_DEPTH_BITS;
    localparam int unsigned BEAT_BITS = PAYLOAD_BITS * WORDS_PER_BEAT;
    localparam int unsigned WIDX_BITS = (WORDS_PER_BEAT > 1) ? $clog2(WORDS_PER_BEAT) : 1;
    localparam int unsigned CRED_BITS =
        (FREESPACE_UPDATE_SIZE > 1) ? $clog2(FREESPACE_UPDATE_SIZE) : 1;

    logic [PAYLOAD_BITS-1:0]    r_mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_BITS-1:0] r_rd_ptr;
    logic [FIFO_DEPTH_BITS:0]   r_count;
    logic [BEAT_BITS-1:0]       r_beat;
    logic [WIDX_BITS-1:0]       r_widx;
    logic                       r_vld;
    logic [CRED_BITS-1:0]       r_pop_cnt;
    logic                       r_credit;
    logic                       r_overflow;
    logic [CNT_BITS-1:0]        r_full_cnt;
    logic [CNT_BITS-1:0]        r_empty_cnt;
    logic [CNT_BITS-1:0]        r_read_cnt;

    logic w_full, w_empty, w_push, w_pop, w_xfer, w_last, w_wrap;

    // Full/empty come from the registered count, so a same-cycle pop never rescues a push.
    assign w_full  = (r_count == (FIFO_DEPTH_BITS + 1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_xfer  = r_vld & i_ack;
    assign w_pop   = ~w_empty & (~r_vld | i_ack);
    assign w_push  = i_wr & ~w_full;
    assign w_last  = (r_widx == WIDX_BITS'(WORDS_PER_BEAT - 1));
    assign w_wrap  = (r_pop_cnt == CRED_BITS'(FREESPACE_UPDATE_SIZE - 1));

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push != w_pop) begin
                r_count <= w_push ? r_count + 1'b1 : r_count - 1'b1;
            end
        end
    end

    // A transfer and the load of the next beat's word 0 may share an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_beat <= '0;
            r_widx <= '0;
            r_vld  <= 1'b0;
        end else begin
            if (w_xfer) r_vld <= 1'b0;
            if (w_pop) begin
                r_beat[r_widx*PAYLOAD_BITS +: PAYLOAD_BITS] <= r_mem[r_rd_ptr];
                r_widx <= w_last ? '0 : r_widx + 1'b1;
                if (w_last) r_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pop_cnt   <= '0;
            r_credit    <= 1'b0;
            r_overflow  <= 1'b0;
            r_full_cnt  <= '0;
            r_empty_cnt <= '0;
            r_read_cnt  <= '0;
        end else begin
            r_credit <= w_pop & w_wrap;
            if (w_pop) r_pop_cnt <= w_wrap ? '0 : r_pop_cnt + 1'b1;
            if (i_wr && w_full) r_overflow <= 1'b1;
            if (!i_done) begin
                if (w_full)  r_full_cnt  <= r_full_cnt + 1'b1;
                if (w_empty) r_empty_cnt <= r_empty_cnt + 1'b1;
                if (w_xfer)  r_read_cnt  <= r_read_cnt + 1'b1;
            end
        end
    end

    assign o_dout      = r_beat;
    assign o_vld       = r_vld;
    assign o_credit    = r_credit;
    assign o_full_cnt  = r_full_cnt;
    assign o_empty_cnt = r_empty_cnt;
    assign o_read_cnt  = r_read_cnt;
    assign o_overflow  = r_overflow;
    assign o_stall     = w_full & r_vld & ~i_ack;

endmodule

// File: rtl/input_port_cluster_gen.sv
// Input port cluster: steers ingress packets to per-port channels by destination port
// and programmed source, and reduces the per-channel stall conditions.
module input_port_cluster_gen
    import input_port_cluster_gen_pkg::*;
#(
    parameter int unsigned NUM_IN_PORTS          = 4,
    parameter int unsigned PORT_BASE             = 2,
    parameter int unsigned FIFO_DEPTH_BITS       = 7,
    parameter int unsigned WORDS_PER_BEAT        = 4,
    parameter int unsigned FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic [PACKET_BITS-1:0]                              stream_in,
    input  logic [CTRL_BITS*NUM_IN_PORTS-1:0]                   in_control_reg,
    output logic [NUM_IN_PORTS-1:0]                             freespace_update,
    output logic [PAYLOAD_BITS*WORDS_PER_BEAT*NUM_IN_PORTS-1:0] dout2user,
    output logic [NUM_IN_PORTS-1:0]                             vld2user,
    input  logic [NUM_IN_PORTS-1:0]                             ack_user2b_in,
    input  logic                                                is_done_mode,
    output logic [CNT_BITS*NUM_IN_PORTS-1:0]                    input_port_full_cnt,
    output logic [CNT_BITS*NUM_IN_PORTS-1:0]                    input_port_empty_cnt,
    output logic [CNT_BITS*NUM_IN_PORTS-1:0]                    input_port_read_cnt,
    output logic [NUM_IN_PORTS-1:0]                             overflow,
    output logic                                                input_port_cluster_stall_condition
);

    localparam int unsigned BEAT_BITS = PAYLOAD_BITS * WORDS_PER_BEAT;

    logic [NUM_IN_PORTS-1:0] w_match;
    logic [NUM_IN_PORTS-1:0] w_stall;
    logic                    w_unused_fields;

    // dst_leaf is filtered upstream and the reserved field carries nothing.
    assign w_unused_fields = ^{stream_in[DST_LEAF_LSB +: NUM_LEAF_BITS],
                               stream_in[SRC_PORT_LSB-1:PAYLOAD_BITS]};

    for (genvar g = 0; g < NUM_IN_PORTS; g++) begin : g_chan
        logic [CTRL_BITS-1:0] w_ctrl;

        assign w_ctrl = in_control_reg[ctrl_lsb(g) +: CTRL_BITS];
        assign w_match[g] = stream_in[VALID_POS]
            && (stream_in[DST_PORT_LSB +: NUM_PORT_BITS] == NUM_PORT_BITS'(PORT_BASE + g))
            && (stream_in[SRC_LEAF_LSB +: NUM_LEAF_BITS] == w_ctrl[NUM_PORT_BITS +: NUM_LEAF_BITS])
            && (stream_in[SRC_PORT_LSB +: NUM_PORT_BITS] == w_ctrl[NUM_PORT_BITS-1:0]);

        input_port_cluster_gen_chan #(
            .FIFO_DEPTH_BITS      (FIFO_DEPTH_BITS),
            .WORDS_PER_BEAT       (WORDS_PER_BEAT),
            .FREESPACE_UPDATE_SIZE(FREESPACE_UPDATE_SIZE)
        ) u_chan (
            .i_clk      (clk),
            .i_rst_n    (reset),
            .i_wr       (w_match[g]),
            .i_wdata    (stream_in[PAYLOAD_BITS-1:0]),
            .i_ack      (ack_user2b_in[g]),
            .i_done     (is_done_mode),
            .o_dout     (dout2user[g*BEAT_BITS +: BEAT_BITS]),
            .o_vld      (vld2user[g]),
            .o_credit   (freespace_update[g]),
            .o_full_cnt (input_port_full_cnt[g*CNT_BITS +: CNT_BITS]),
            .o_empty_cnt(input_port_empty_cnt[g*CNT_BITS +: CNT_BITS]),
            .o_read_cnt (input_port_read_cnt[g*CNT_BITS +: CNT_BITS]),
            .o_overflow (overflow[g]),
            .o_stall    (w_stall[g])
        );
    end

    assign input_port_cluster_stall_condition = |w_stall;

endmodule

// File: tb/tb_input_port_cluster_gen.sv
// Bench for input_port_cluster_gen: directed scenarios plus random traffic, all outputs
// compared every cycle against a queue-based channel model.
module tb_input_port_cluster_gen;

    localparam int NP    = 4;
    localparam int W     = 4;
    localparam int DEPTH = 128;
    localparam int FSU   = 64;
    localparam int PB    = 2;
    localparam int BW    = 64 * W;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic [96:0]       pkt   = '0;
    logic [10*NP-1:0]  ctrl  = '0;
    logic [NP-1:0]     ack   = '0;
    logic              done  = 1'b0;
    logic [NP-1:0]     fsu_o;
    logic [NP-1:0]     vld_o;
    logic [NP-1:0]     ovf_o;
    logic [BW*NP-1:0]  dout;
    logic [32*NP-1:0]  full_cnt;
    logic [32*NP-1:0]  empty_cnt;
    logic [32*NP-1:0]  read_cnt;
    logic              stall;

    always #5 clk = ~clk;

    input_port_cluster_gen #(
        .NUM_IN_PORTS         (NP),
        .PORT_BASE            (PB),
        .FIFO_DEPTH_BITS      (7),
        .WORDS_PER_BEAT       (W),
        .FREESPACE_UPDATE_SIZE(FSU)
    ) dut (
        .clk                               (clk),
        .reset                             (rst_n),
        .stream_in                         (pkt),
        .in_control_reg                    (ctrl),
        .freespace_update                  (fsu_o),
        .dout2user                         (dout),
        .vld2user                          (vld_o),
        .ack_user2b_in                     (ack),
        .is_done_mode                      (done),
        .input_port_full_cnt               (full_cnt),
        .input_port_empty_cnt              (empty_cnt),
        .input_port_read_cnt               (read_cnt),
        .overflow                          (ovf_o),
        .input_port_cluster_stall_condition(stall)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, BW'(act), BW'(exp));
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk(name, BW'(act), BW'(exp));
    endtask

    function automatic logic [5:0] leaf_of(input int ch);
        return 6'(16 + ch);
    endfunction

    function automatic logic [3:0] port_of(input int ch);
        return 4'(5 + ch);
    endfunction

    function automatic logic [96:0] mkpkt(input logic [3:0] dport, input logic [5:0] sleaf,
                                          input logic [3:0] sport, input logic [63:0] pay);
        return {1'b1, 6'h2A, dport, sleaf, sport, 12'hABC, pay};
    endfunction

    function automatic bit hits(input logic [96:0] p, input int ch);
        return p[96] && p[89:86] == 4'(PB + ch) && p[85:80] == leaf_of(ch)
            && p[79:76] == port_of(ch);
    endfunction

    // Channel model: FIFO contents, words gathered for the pending beat, presented beat.
    logic [63:0]    m_fifo [NP][$];
    logic [63:0]    m_pend [NP][$];
    bit             m_vld  [NP];
    logic [BW-1:0]  m_beat [NP];
    bit             m_cred [NP];
    bit             m_ovf  [NP];
    int unsigned    m_pops [NP];
    int unsigned    m_full [NP];
    int unsigned    m_empty[NP];
    int unsigned    m_read [NP];

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_fifo[i].delete();
            m_pend[i].delete();
            m_vld[i]   = 0;
            m_beat[i]  = '0;
            m_cred[i]  = 0;
            m_ovf[i]   = 0;
            m_pops[i]  = 0;
            m_full[i]  = 0;
            m_empty[i] = 0;
            m_read[i]  = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < NP; i++) begin
            bit full, empty, xfer, pop;
            logic [63:0] w;
            full  = (m_fifo[i].size() == DEPTH);
            empty = (m_fifo[i].size() == 0);
            xfer  = m_vld[i] && ack[i];
            pop   = !empty && (!m_vld[i] || xfer);
            if (!done) begin
                if (full)  m_full[i]++;
                if (empty) m_empty[i]++;
                if (xfer)  m_read[i]++;
            end
            m_cred[i] = 0;
            if (xfer) m_vld[i] = 0;
            if (pop) begin
                w = m_fifo[i].pop_front();
                m_pend[i].push_back(w);
                m_pops[i]++;
                if (m_pops[i] % FSU == 0) m_cred[i] = 1;
                if (m_pend[i].size() == W) begin
                    for (int k = 0; k < W; k++) m_beat[i][64*k +: 64] = m_pend[i][k];
                    m_pend[i].delete();
                    m_vld[i] = 1;
                end
            end
            if (hits(pkt, i)) begin
                if (full) m_ovf[i] = 1;
                else      m_fifo[i].push_back(pkt[63:0]);
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    task automatic compare();
        bit exp_stall;
        exp_stall = 0;
        for (int i = 0; i < NP; i++) begin
            chk1($sformatf("vld[%0d]", i), vld_o[i], m_vld[i]);
            if (m_vld[i]) chk($sformatf("dout[%0d]", i), dout[i*BW +: BW], m_beat[i]);
            chk1($sformatf("credit[%0d]", i), fsu_o[i], m_cred[i]);
            chk1($sformatf("overflow[%0d]", i), ovf_o[i], m_ovf[i]);
            chk32($sformatf("full_cnt[%0d]", i), full_cnt[i*32 +: 32], m_full[i]);
            chk32($sformatf("empty_cnt[%0d]", i), empty_cnt[i*32 +: 32], m_empty[i]);
            chk32($sformatf("read_cnt[%0d]", i), read_cnt[i*32 +: 32], m_read[i]);
            if (m_fifo[i].size() == DEPTH && m_vld[i] && !ack[i]) exp_stall = 1;
        end
        chk1("stall", stall, exp_stall);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) compare();
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_ch(input int ch, input logic [63:0] pay);
        pkt = mkpkt(4'(PB + ch), leaf_of(ch), port_of(ch), pay);
        tick();
        pkt = '0;
    endtask

    task automatic wait_vld(input int ch, input int limit);
        for (int n = 0; n < limit && !vld_o[ch]; n++) tick();
        chk1($sformatf("wait_vld[%0d]", ch), vld_o[ch], 1'b1);
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < NP; i++) begin
            chk({tag, "_dout"}, dout[i*BW +: BW], '0);
            chk({tag, "_cnts"}, BW'({full_cnt[i*32 +: 32], empty_cnt[i*32 +: 32],
                                     read_cnt[i*32 +: 32]}), '0);
        end
        chk({tag, "_flags"}, BW'({vld_o, fsu_o, ovf_o, stall}), '0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk_zero(tag);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int pulses, run, maxrun, r, ch;
        for (int i = 0; i < NP; i++) ctrl[10*i +: 10] = {leaf_of(i), port_of(i)};
        #2;
        do_reset("reset");

        // Two beats on channel 0, first-received word lowest.
        for (int k = 1; k <= 8; k++) send_ch(0, 64'(k));
        wait_vld(0, 20);
        chk("beat1", dout[0 +: BW], {64'd4, 64'd3, 64'd2, 64'd1});
        ack[0] = 1'b1; tick(); ack[0] = 1'b0;
        wait_vld(0, 20);
        chk("beat2", dout[0 +: BW], {64'd8, 64'd7, 64'd6, 64'd5});
        ack[0] = 1'b1; tick(); ack[0] = 1'b0;
        chk32("read_cnt0_two_beats", read_cnt[31:0], 32'd2);

        // Wrong source leaf for channel 1: ignored, channel 1 stays empty.
        do_reset("reset2");
        pkt = mkpkt(4'(PB + 1), leaf_of(1) ^ 6'h01, port_of(1), 64'hDEAD);
        tick();
        pkt = '0;
        repeat (4) tick();
        chk32("wrong_src_empty_cnt1", empty_cnt[32 +: 32], 32'd5);
        chk1("wrong_src_vld1", vld_o[1], 1'b0);

        // Overflow: 4 words sit in the packer, 128 in the FIFO, the next one drops.
        do_reset("reset3");
        for (int k = 0; k < 132; k++) send_ch(0, 64'h1000 + 64'(k));
        chk1("ovf_before_full", ovf_o[0], 1'b0);
        send_ch(0, 64'hFFFF);
        chk1("ovf_after_drop", ovf_o[0], 1'b1);
        chk1("stall_full_unacked", stall, 1'b1);
        ack[0] = 1'b1;
        repeat (140) tick();
        ack[0] = 1'b0;
        chk32("drain_read_cnt", read_cnt[31:0], 32'd33);
        chk1("ovf_sticky", ovf_o[0], 1'b1);

        // Credit: 64 pops under continuous ack give one single-cycle pulse.
        do_reset("reset4");
        ack[0] = 1'b1;
        pulses = 0; run = 0; maxrun = 0;
        for (int k = 0; k < 84; k++) begin
            if (k < 64) pkt = mkpkt(4'(PB), leaf_of(0), port_of(0), 64'(k));
            else        pkt = '0;
            tick();
            if (fsu_o[0]) begin
                run++;
                if (run > maxrun) maxrun = run;
                if (run == 1) pulses++;
            end else begin
                run = 0;
            end
        end
        pkt = '0;
        ack[0] = 1'b0;
        chk32("credit_pulses", 32'(pulses), 32'd1);
        chk32("credit_width", 32'(maxrun), 32'd1);

        // Random interleaved traffic with per-channel back-pressure and done toggling.
        do_reset("reset5");
        for (int c = 0; c < 2000; c++) begin
            r  = $urandom_range(0, 99);
            ch = $urandom_range(0, NP - 1);
            if (r < 60) begin
                pkt = mkpkt(4'(PB + ch), leaf_of(ch), port_of(ch), {$urandom, $urandom});
            end else if (r < 75) begin
                pkt = {1'($urandom), $urandom, $urandom, $urandom};
            end else if (r < 85) begin
                pkt = mkpkt(4'(PB + ch), leaf_of(ch), port_of(ch) ^ 4'h8, {$urandom, $urandom});
            end else begin
                pkt = '0;
            end
            for (int i = 0; i < NP; i++) ack[i] = ($urandom_range(0, 4) <= unsigned'(i));
            if ($urandom_range(0, 199) == 0) done = ~done;
            tick();
        end
        pkt = '0; ack = '0; done = 1'b0;

        // Done mode freezes statistics while data still flows.
        do_reset("reset6");
        repeat (3) tick();
        chk32("empty_cnt2_running", empty_cnt[64 +: 32], 32'd3);
        done = 1'b1;
        repeat (10) tick();
        chk32("empty_cnt2_frozen", empty_cnt[64 +: 32], 32'd3);
        ack[2] = 1'b1;
        for (int k = 0; k < 4; k++) send_ch(2, 64'h20 + 64'(k));
        wait_vld(2, 10);
        chk("done_mode_beat", dout[2*BW +: BW], {64'h23, 64'h22, 64'h21, 64'h20});
        tick();
        chk32("read_cnt2_frozen", read_cnt[64 +: 32], 32'd0);
        ack[2] = 1'b0;
        done = 1'b0;

        // Reset mid-beat discards the partial beat.
        send_ch(3, 64'h31);
        send_ch(3, 64'h32);
        tick();
        do_reset("midbeat");
        ack[3] = 1'b1;
        for (int k = 1; k <= 4; k++) send_ch(3, 64'h40 + 64'(k));
        wait_vld(3, 10);
        chk("post_reset_beat", dout[3*BW +: BW], {64'h44, 64'h43, 64'h42, 64'h41});
        tick();
        ack[3] = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
